// File: rtl/uart_tx_arbiter_pkg.sv
`default_nettype none
// ==================================================================
// uart_tx_arbiter_pkg : arbiter state encoding and frame-config layout
// Rev 1.0
// ==================================================================
package uart_tx_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_START     = 2'd1,
      ST_WAIT_BUSY = 2'd2,
      ST_WAIT_DONE = 2'd3
   } arb_state_t;

   localparam int DEF_N_REQ           = 4;
   localparam int DEF_MAX_UART_DATA_W = 8;
   localparam int DEF_TOTAL_CONF_W    = 5;

   // Frame config packing: {data[1:0], stop[1:0], parity_en}
   localparam int CONF_PARITY_BIT = 0;
   localparam int CONF_STOP_LSB   = 1;
   localparam int CONF_DATA_LSB   = 3;

endpackage
`default_nettype wire

// File: rtl/uart_tx_arbiter_rr_pick.sv
`default_nettype none
// ==================================================================
// uart_rr_pick : combinational rotating-priority picker, search starts at last_ptr+1
// Rev 1.0
// ==================================================================
module uart_rr_pick #(
   parameter int N_REQ = 4,
   parameter int SEL_W = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [SEL_W-1:0] last_ptr,
   output logic             valid,
   output logic [SEL_W-1:0] idx
);

   assign valid = |req;

   // Scan from farthest to nearest so the nearest requester after last_ptr wins.
   always_comb begin
      int j;
      j   = 0;
      idx = '0;
      for (int i = N_REQ; i >= 1; i--) begin
         j = (int'(last_ptr) + i) % N_REQ;
         if (req[j]) idx = SEL_W'(j);
      end
   end

endmodule
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ==================================================================
// uart_tx_arbiter : round-robin owner of the shared UART Tx path.
// Optional macro UART_ARB_LOCK_EN adds a burst-lock hint.  Rev 1.0
// ==================================================================
module uart_tx_arbiter
   import uart_tx_arbiter_pkg::*;
#(
   parameter int N_REQ           = DEF_N_REQ,
   parameter int REQ_SEL_W       = $clog2(N_REQ),
   parameter int MAX_UART_DATA_W = DEF_MAX_UART_DATA_W,
   parameter int TOTAL_CONF_W    = DEF_TOTAL_CONF_W
) (
   input  logic                              clk_i,
   input  logic                              rst_ni,
   input  logic [N_REQ-1:0]                  req_i,
   input  logic [N_REQ*MAX_UART_DATA_W-1:0]  req_data_i,
   input  logic [N_REQ*TOTAL_CONF_W-1:0]     req_conf_i,
`ifdef UART_ARB_LOCK_EN
   input  logic [N_REQ-1:0]                  req_lock_i,
`endif
   output logic [N_REQ-1:0]                  ack_o,
   input  logic                              tx_done_i,
   input  logic                              tx_busy_i,
   output logic                              tx_en_o,
   output logic                              tx_start_o,
   output logic [MAX_UART_DATA_W-1:0]        tx_data_o,
   output logic [TOTAL_CONF_W-1:0]           tx_conf_o,
   output logic [REQ_SEL_W-1:0]              owner_o,
   output logic                              active_o
);

   arb_state_t           state;
   logic [REQ_SEL_W-1:0] last_ptr;
   logic                 pick_valid;
   logic [REQ_SEL_W-1:0] pick_idx;
   logic [REQ_SEL_W-1:0] grant_idx;
   logic                 keep_ptr;
   logic                 xfer_done;

   uart_rr_pick #(
      .N_REQ (N_REQ),
      .SEL_W (REQ_SEL_W)
   ) u_pick (
      .req      (req_i),
      .last_ptr (last_ptr),
      .valid    (pick_valid),
      .idx      (pick_idx)
   );

   assign xfer_done = tx_done_i & ((state == ST_WAIT_BUSY) | (state == ST_WAIT_DONE));

`ifdef UART_ARB_LOCK_EN
   logic lock_hold;

   // A locked owner that still requests keeps the channel for its next character.
   assign keep_ptr  = req_lock_i[owner_o] & req_i[owner_o];
   assign grant_idx = (lock_hold & req_i[owner_o]) ? owner_o : pick_idx;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         lock_hold <= 1'b0;
      end else if (xfer_done) begin
         lock_hold <= keep_ptr;
      end else if (state == ST_IDLE && pick_valid) begin
         lock_hold <= 1'b0;
      end
   end
`else
   assign keep_ptr  = 1'b0;
   assign grant_idx = pick_idx;
`endif

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state      <= ST_IDLE;
         last_ptr   <= REQ_SEL_W'(N_REQ - 1);
         ack_o      <= '0;
         tx_en_o    <= 1'b0;
         tx_start_o <= 1'b0;
         tx_data_o  <= '0;
         tx_conf_o  <= '0;
         owner_o    <= '0;
         active_o   <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (pick_valid) begin
                  state            <= ST_START;
                  tx_data_o        <= req_data_i[grant_idx*MAX_UART_DATA_W +: MAX_UART_DATA_W];
                  tx_conf_o        <= req_conf_i[grant_idx*TOTAL_CONF_W +: TOTAL_CONF_W];
                  owner_o          <= grant_idx;
                  ack_o            <= '0;
                  ack_o[grant_idx] <= 1'b1;
                  tx_start_o       <= 1'b1;
                  tx_en_o          <= 1'b1;
                  active_o         <= 1'b1;
               end
            end
            ST_START: begin
               state      <= ST_WAIT_BUSY;
               ack_o      <= '0;
               tx_start_o <= 1'b0;
            end
            ST_WAIT_BUSY, ST_WAIT_DONE: begin
               // A done seen before busy still counts as completion.
               if (tx_done_i) begin
                  state    <= ST_IDLE;
                  tx_en_o  <= 1'b0;
                  active_o <= 1'b0;
                  if (!keep_ptr) last_ptr <= owner_o;
               end else if (state == ST_WAIT_BUSY && tx_busy_i) begin
                  state <= ST_WAIT_DONE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ==================================================================
// tb_uart_tx_arbiter : directed and randomized checks against a round-robin model
// Rev 1.0
// ==================================================================
module tb_uart_tx_arbiter;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic [3:0]  req_i;
   logic [31:0] req_data_i;
   logic [19:0] req_conf_i;
   logic [3:0]  req_lock;
   logic [3:0]  ack_o;
   logic        tx_done_i;
   logic        tx_busy_i;
   logic        tx_en_o;
   logic        tx_start_o;
   logic [7:0]  tx_data_o;
   logic [4:0]  tx_conf_o;
   logic [1:0]  owner_o;
   logic        active_o;

   int tests_run    = 0;
   int tests_failed = 0;
   int model_last   = 3;

   uart_tx_arbiter dut (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .req_i      (req_i),
      .req_data_i (req_data_i),
      .req_conf_i (req_conf_i),
`ifdef UART_ARB_LOCK_EN
      .req_lock_i (req_lock),
`endif
      .ack_o      (ack_o),
      .tx_done_i  (tx_done_i),
      .tx_busy_i  (tx_busy_i),
      .tx_en_o    (tx_en_o),
      .tx_start_o (tx_start_o),
      .tx_data_o  (tx_data_o),
      .tx_conf_o  (tx_conf_o),
      .owner_o    (owner_o),
      .active_o   (active_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: first requester found walking upward from the last owner + 1.
   function automatic int model_pick(input logic [3:0] r, input int lp);
      logic [3:0] rr;
      rr = r;
      for (int k = 1; k <= 4; k++) begin
         if (rr[(lp + k) % 4]) return (lp + k) % 4;
      end
      return -1;
   endfunction

   task automatic xfer(input logic [3:0] req, input int busy_n, input bit spur_done);
      int         w;
      logic [7:0] exp_d;
      logic [4:0] exp_c;
      req_i = req;
      w     = model_pick(req, model_last);
      exp_d = req_data_i[w*8 +: 8];
      exp_c = req_conf_i[w*5 +: 5];
      step();
      check("start_pulse", 32'(tx_start_o), 32'd1);
      check("ack_onehot", 32'(ack_o), 32'(4'b0001 << w));
      check("owner", 32'(owner_o), 32'(w));
      check("data", 32'(tx_data_o), 32'(exp_d));
      check("conf", 32'(tx_conf_o), 32'(exp_c));
      check("en_start", 32'({active_o, tx_en_o}), 32'd3);
      if (spur_done) tx_done_i = 1'b1;
      step();
      tx_done_i = 1'b0;
      check("start_one_cycle", 32'({tx_start_o, ack_o}), 32'd0);
      check("active_wait", 32'(active_o), 32'd1);
      req_data_i = $urandom;
      req_conf_i = 20'($urandom);
      if (busy_n > 0) begin
         tx_busy_i = 1'b1;
         for (int i = 0; i < busy_n; i++) begin
            req_data_i = $urandom;
            step();
            check("data_stable", 32'(tx_data_o), 32'(exp_d));
            check("active_busy", 32'(active_o), 32'd1);
         end
      end
      tx_done_i = 1'b1;
      step();
      tx_done_i = 1'b0;
      tx_busy_i = 1'b0;
      check("idle_after_done", 32'({active_o, tx_en_o, tx_start_o}), 32'd0);
      check("data_held_idle", 32'(tx_data_o), 32'(exp_d));
      model_last = w;
   endtask

   initial begin
      rst_ni     = 1'b0;
      req_i      = '0;
      req_data_i = '0;
      req_conf_i = '0;
      req_lock   = '0;
      tx_done_i  = 1'b0;
      tx_busy_i  = 1'b0;
      repeat (3) step();
      check("rst_ack", 32'(ack_o), 32'd0);
      check("rst_ctrl", 32'({tx_en_o, tx_start_o, active_o}), 32'd0);
      check("rst_data", 32'(tx_data_o), 32'd0);
      check("rst_conf", 32'(tx_conf_o), 32'd0);
      check("rst_owner", 32'(owner_o), 32'd0);
      rst_ni = 1'b1;

      // All requesting after reset: requester 0 first, then strict rotation.
      req_data_i = $urandom;
      req_conf_i = 20'($urandom);
      for (int i = 0; i < 8; i++) begin
         xfer(4'b1111, i % 3, 1'b0);
         check("fair_order", 32'(owner_o), 32'(i % 4));
      end

      // Single requester with a known character.
      req_data_i[23:16] = 8'hA5;
      xfer(4'b0100, 2, 1'b0);
      check("single_a5", 32'(tx_data_o), 32'h0000_00A5);

      // Spurious done in IDLE must leave pointer and outputs untouched.
      req_i     = '0;
      tx_done_i = 1'b1;
      step();
      tx_done_i = 1'b0;
      check("spur_idle", 32'({active_o, tx_en_o, tx_start_o, ack_o}), 32'd0);
      step();
      check("spur_idle2", 32'(active_o), 32'd0);

      // Randomized traffic, including done pulses during START.
      for (int i = 0; i < 24; i++) begin
         req_data_i = $urandom;
         req_conf_i = 20'($urandom);
         xfer(4'($urandom_range(1, 15)), int'($urandom_range(0, 3)), 1'($urandom));
      end

      // Reset in WAIT_DONE abandons the character and restores the pointer.
      req_i = 4'b0010;
      step();
      check("pre_rst_owner", 32'(owner_o), 32'(model_pick(4'b0010, model_last)));
      step();
      tx_busy_i = 1'b1;
      step();
      check("pre_rst_active", 32'(active_o), 32'd1);
      rst_ni = 1'b0;
      step();
      tx_busy_i = 1'b0;
      check("midrst_ctrl", 32'({active_o, tx_en_o, tx_start_o, ack_o}), 32'd0);
      check("midrst_owner", 32'(owner_o), 32'd0);
      check("midrst_data", 32'(tx_data_o), 32'd0);
      model_last = 3;

      // Reset on the very edge that would have granted: no ack appears.
      req_i = 4'b1111;
      step();
      check("rst_no_ack", 32'({ack_o, tx_start_o, active_o}), 32'd0);
      rst_ni     = 1'b1;
      req_data_i = $urandom;
      xfer(4'b1111, 1, 1'b0);
      check("post_rst_owner0", 32'(owner_o), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
`default_nettype wire
